// File: rtl/fifo_syn.sv
// rtl/fifo_syn.sv - single-clock FIFO with cs-gated strobes, registered read data and full/empty flags.
// Optional FIFO_SYN_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module fifo_syn #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
`ifdef FIFO_SYN_ERR_FLAGS_EN
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
`else
    output logic                  full
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  wr_accept;
    logic                  rd_accept;

    // Flags come from the pre-edge count, so a write while full is dropped even if a read frees a slot.
    assign empty     = (count == '0);
    assign full      = (count == DEPTH_CNT);
    assign wr_accept = cs && wr_en && !full;
    assign rd_accept = cs && rd_en && !empty;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_accept) begin
                rd_ptr   <= rd_ptr + AW'(1);
                data_out <= mem[rd_ptr];
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_SYN_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (cs && wr_en && full) begin
                overflow <= 1'b1;
            end
            if (cs && rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_syn.sv
// tb/tb_fifo_syn.sv - scoreboard bench for fifo_syn against a queue-based reference model.
module tb_fifo_syn;

    localparam int DEPTH = 8;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
`ifdef FIFO_SYN_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    fifo_syn #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cs(cs),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .data_in(data_in),
        .data_out(data_out),
        .empty(empty),
`ifdef FIFO_SYN_ERR_FLAGS_EN
        .full(full),
        .overflow(overflow),
        .underflow(underflow)
`else
        .full(full)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] dout;
        logic          emp;
        logic          ful;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_dout;
    logic          model_ovf;
    logic          model_unf;
    int            n_checks = 0;
    int            n_fails  = 0;

    function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("data_out", data_out, e.dout);
            check("empty", DW'(empty), DW'(e.emp));
            check("full", DW'(full), DW'(e.ful));
`ifdef FIFO_SYN_ERR_FLAGS_EN
            check("overflow", DW'(overflow), DW'(e.ovf));
            check("underflow", DW'(underflow), DW'(e.unf));
`endif
        end
    end

    task automatic model_clear();
        model_q.delete();
        model_dout = '0;
        model_ovf  = 1'b0;
        model_unf  = 1'b0;
        exp_q.delete();
    endtask

    // Called at posedge+1: applies inputs, predicts post-edge outputs, and queues them at the edge.
    task automatic step(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
        bit   wa, ra;
        exp_t e;
        cs = c; wr_en = w; rd_en = r; data_in = d;
        wa = c && w && (model_q.size() < DEPTH);
        ra = c && r && (model_q.size() > 0);
        if (c && w && model_q.size() == DEPTH) model_ovf = 1'b1;
        if (c && r && model_q.size() == 0)     model_unf = 1'b1;
        if (ra) model_dout = model_q.pop_front();
        if (wa) model_q.push_back(d);
        e.dout = model_dout;
        e.emp  = (model_q.size() == 0);
        e.ful  = (model_q.size() == DEPTH);
        e.ovf  = model_ovf;
        e.unf  = model_unf;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] d); step(1'b1, 1'b1, 1'b0, d); endtask
    task automatic rd();                       step(1'b1, 1'b0, 1'b1, '0); endtask
    task automatic idle();                     step(1'b0, 1'b0, 1'b0, '0); endtask

    task automatic check_reset_state(string tag);
        check({tag, "_empty"}, DW'(empty), DW'(1'b1));
        check({tag, "_full"}, DW'(full), DW'(1'b0));
        check({tag, "_dout"}, data_out, '0);
`ifdef FIFO_SYN_ERR_FLAGS_EN
        check({tag, "_ovf"}, DW'(overflow), DW'(1'b0));
        check({tag, "_unf"}, DW'(underflow), DW'(1'b0));
`endif
    endtask

    initial begin
        model_clear();
        repeat (10) @(posedge clk);
        #1;
        check_reset_state("reset_hold");
        rst_n = 1'b1;

        // basic order
        for (int i = 1; i <= 4; i++) wr(DW'(i));
        repeat (4) rd();
        idle();

        // empty boundary and underflow
        for (int i = 0; i < 8; i++) begin
            wr(DW'(i));
            rd();
        end
        rd();
        idle();

        // full boundary, drop, wrap with offset pointers
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 3 * pass; i++) wr(DW'(100 + i));
            for (int i = 0; i < 3 * pass; i++) rd();
            for (int i = 0; i < DEPTH; i++) wr(DW'(i));
            wr(DW'(99));
            for (int i = 0; i < DEPTH; i++) rd();
            idle();
        end

        // held write strobe
        repeat (11) step(1'b1, 1'b1, 1'b0, DW'(5));
        repeat (DEPTH) rd();

        // simultaneous read+write at mid, full and empty
        for (int i = 0; i < 3; i++) wr(DW'(32'hA0 + i));
        step(1'b1, 1'b1, 1'b1, DW'(32'hAA));
        repeat (3) rd();
        for (int i = 0; i < DEPTH - 3; i++) wr(DW'(32'hB0 + i));
        for (int i = 0; i < 3; i++) wr(DW'(32'hC0 + i));
        step(1'b1, 1'b1, 1'b1, DW'(32'hDD));
        repeat (DEPTH) rd();
        step(1'b1, 1'b1, 1'b1, DW'(32'hEE));
        rd();

        // randomized traffic including cs low
        for (int i = 0; i < 400; i++) begin
            step(1'b1 && ($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), $urandom);
        end

        // async reset mid-operation, without a clock edge
        for (int i = 0; i < 5; i++) wr(DW'(32'h50 + i));
        rd();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_state("async_reset");
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) wr(DW'(32'h70 + i));
        repeat (DEPTH + 1) rd();
        idle();

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fifo_syn.md
# fifo_syn

Single-clock synchronous FIFO buffering DATA_WIDTH-bit words between a producer and consumer in the same clock domain. Chip-select gated write and read strobes, registered read data, and full/empty status flags. General-purpose rate-smoothing buffer for datapath blocks.

## Interface
- FIFO_DEPTH, 8, number of storage entries; power of two, ≥ 2.
- DATA_WIDTH, 32, word width in bits.

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; one clock, asynchronous, active-low.
- cs  input  1  chip select; wr_en and rd_en are ignored while low.
- wr_en  input  1  write strobe; one word per cycle while high.
- rd_en  input  1  read strobe; one word per cycle while high.
- data_in  input  DATA_WIDTH  write data, sampled with wr_en.
- data_out  output  DATA_WIDTH  registered read data.
- empty  output  1  high when FIFO holds 0 words.
- full  output  1  high when FIFO holds FIFO_DEPTH words.

## Operation
- Storage: FIFO_DEPTH × DATA_WIDTH register array; write pointer, read pointer ($clog2(FIFO_DEPTH) bits, natural wrap), occupancy count ($clog2(FIFO_DEPTH)+1 bits).
- Write accepted when cs && wr_en && !full: mem[wr_ptr] <= data_in, wr_ptr++.
- Read accepted when cs && rd_en && !empty: data_out <= mem[rd_ptr], rd_ptr++.
- Write while full: dropped, no state change. Read while empty: ignored, data_out holds.
- Simultaneous read+write with 0 < count < FIFO_DEPTH: both accepted, count unchanged.
- Simultaneous read+write when full: read accepted; write dropped (full is evaluated pre-edge). Count decrements.
- Simultaneous read+write when empty: write accepted, read ignored; count becomes 1.
- empty = (count == 0); full = (count == FIFO_DEPTH); both combinational from count.
- data_out holds last read word until the next accepted read.
- Memory contents not reset.

## Timing
- Reset (async assert, sync-safe release): pointers = 0, count = 0, data_out = 0, empty = 1, full = 0.
- Reset mid-operation discards all contents immediately; first write after release lands at entry 0.
- Write-to-empty deassert: 1 cycle (empty low after the edge that accepts the write).
- Read latency: data_out valid after the rising edge that accepts the read (1 cycle).
- Earliest read of a new word: the cycle after its write edge.
- Pointer wrap at FIFO_DEPTH-1 -> 0 is seamless; FIFO order is preserved across wrap.
- Throughput: one write and one read per cycle sustained.

## Configuration
- FIFO_SYN_ERR_FLAGS_EN: when defined, adds outputs overflow (1) and underflow (1). Each is a sticky flag that sets on a dropped write (cs && wr_en && full) or an ignored read (cs && rd_en && empty), and clears only on reset (reset value 0).
- Without the macro: these ports and their logic are absent, and dropped or ignored accesses are silent.

## Test plan
- Reset: hold rst_n low 10 cycles -> empty=1, full=0, data_out=0; assert rst_n async mid-cycle -> flags reset without a clock edge.
- Basic order: release reset; single-cycle writes 1,2,3,4; four single-cycle reads -> data_out 1,2,3,4 one cycle after each read; empty=1 after the fourth read.
- Empty boundary: alternate write(i)/read for i=0..7 -> each read returns i, empty toggles 0/1, full stays 0; extra read on empty -> data_out holds 7 (underflow=1 with the macro).
- Full boundary and wrap: write 0..7 -> full=1 after the 8th; write 99 -> dropped (overflow=1 with the macro); read 8 times -> 0..7 in order, empty=1; repeat with offset pointers -> order preserved.
- Held strobe: wr_en held high 11 cycles with data_in=5 from empty -> 8 words accepted, full=1, remaining 3 dropped.
- Simultaneous: with 3 words stored, assert wr_en+rd_en for one cycle -> count stays 3, oldest word read out; full + both -> count 7; empty + both -> count 1, data_out unchanged.
